// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int SA_W_DEF = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if import serial_adder_pkg::*; #(parameter int W = SA_W_DEF);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic          ovf;

   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder assembled from two half-adder cells and an OR.
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s0, c0, c1;

   half_adder_cell u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
   half_adder_cell u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

   assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, one bit per clock through a single full-adder cell.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder import serial_adder_pkg::*; #(
   parameter int W = SA_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

   sa_state_t         state, state_nx;
   logic [W-1:0]      sa, sb, ss;
   logic              carry;
   logic [CNT_W-1:0]  cnt;
   logic              bit_s, bit_co;
   logic              last, accept;

   assign last   = (cnt == CNT_W'(W-1));
   assign accept = bus.in_valid && bus.in_ready;

   full_adder_cell u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept)        state_nx = RUN;
         RUN:     if (last)          state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
   end

   // ss fills from the top so the LSB lands in bit 0 after W shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         ss    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               sa    <= bus.a;
               sb    <= bus.b;
               carry <= bus.cin;
               cnt   <= '0;
            end
            RUN: begin
               ss    <= {bit_s, ss[W-1:1]};
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               carry <= bit_co;
               cnt   <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.sum  = ss;
   assign bus.cout = carry;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // On the MSB cycle, carry holds the carry into the MSB and bit_co the carry out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 ovf_q <= 1'b0;
      else if (state == RUN && last)           ovf_q <= carry ^ bit_co;
      else if (state == DONE && bus.out_ready) ovf_q <= 1'b0;
   end

   assign bus.ovf = ovf_q;
`endif

endmodule
